sram_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single SRAM controller port between the instruction-fetch path (read-only, requester 0) and the data-cache controller (read/write, requester 1). It holds one grant per SRAM transaction, alternates round-robin when both sides contend, and forwards the granted requester's address, data and enables to the SRAM controller. A per-transaction watchdog prevents a stalled SRAM from hanging the pipeline.

---
 rtl/sram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sram_port_arbiter -- round-robin share of one SRAM controller port between
// the instruction fetch (m0, read-only) and the data cache (m1, read/write).
// Revision: 1.0
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 32,
    parameter int LINE_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_r_en,
    output logic [LINE_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_r_en,
    input  logic              m1_w_en,
    output logic [LINE_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_r_en,
    output logic              sram_w_en,
    input  logic [LINE_W-1:0] sram_rdata,
    input  logic              sram_ready,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [7:0] C_WD_LIMIT = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        last_grant_q;
    logic [7:0]  wait_cnt_q;
    logic        timeout_err_q;

    logic w_req0;
    logic w_req1;
    logic w_busy0;
    logic w_busy1;
    logic w_owner_req;
    logic w_wd_limit;
    logic w_done;

    assign w_req0      = m0_r_en;
    assign w_req1      = m1_r_en | m1_w_en;
    assign w_busy0     = (state_q == BUSY0);
    assign w_busy1     = (state_q == BUSY1);
    assign w_owner_req = w_busy0 ? w_req0 : w_req1;
    assign w_wd_limit  = (wait_cnt_q == C_WD_LIMIT);
    // sram_ready takes precedence over the watchdog when both land together
    assign w_done      = sram_ready | w_wd_limit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            wait_cnt_q    <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_cnt_q <= 8'd0;
                    if (w_req0 && (!w_req1 || last_grant_q)) begin
                        state_q <= BUSY0;
                    end else if (w_req1) begin
                        state_q <= BUSY1;
                    end
                end
                BUSY0, BUSY1: begin
                    if (!w_owner_req) begin
                        // requester withdrew: abandon silently, fairness untouched
                        state_q    <= IDLE;
                        wait_cnt_q <= 8'd0;
                    end else if (w_done) begin
                        state_q      <= IDLE;
                        wait_cnt_q   <= 8'd0;
                        last_grant_q <= w_busy1;
                        if (!sram_ready) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    wait_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign sram_address = w_busy0 ? m0_address :
                          w_busy1 ? m1_address : '0;
    assign sram_w_en    = w_busy1 & m1_w_en;
    assign sram_r_en    = (w_busy0 & m0_r_en) | (w_busy1 & m1_r_en & ~m1_w_en);
    assign sram_wdata   = sram_w_en ? m1_wdata : '0;

    assign m0_ready = ~w_req0 | (w_busy0 & w_done);
    assign m1_ready = ~w_req1 | (w_busy1 & w_done);
    assign m0_rdata = sram_rdata;
    assign m1_rdata = sram_rdata;

    assign grant       = {w_busy1, w_busy0};
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_port_arbiter -- directed self-checking bench for sram_port_arbiter.
// Revision: 1.0
// ============================================================================
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] m0_address;
    logic        m0_r_en;
    logic [63:0] m0_rdata;
    logic        m0_ready;
    logic [17:0] m1_address;
    logic [31:0] m1_wdata;
    logic        m1_r_en;
    logic        m1_w_en;
    logic [63:0] m1_rdata;
    logic        m1_ready;
    logic [17:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    sram_port_arbiter #(
        .ADDR_W (18),
        .DATA_W (32),
        .LINE_W (64),
        .TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_address  (m0_address),
        .m0_r_en     (m0_r_en),
        .m0_rdata    (m0_rdata),
        .m0_ready    (m0_ready),
        .m1_address  (m1_address),
        .m1_wdata    (m1_wdata),
        .m1_r_en     (m1_r_en),
        .m1_w_en     (m1_w_en),
        .m1_rdata    (m1_rdata),
        .m1_ready    (m1_ready),
        .sram_address(sram_address),
        .sram_wdata  (sram_wdata),
        .sram_r_en   (sram_r_en),
        .sram_w_en   (sram_w_en),
        .sram_rdata  (sram_rdata),
        .sram_ready  (sram_ready),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        m0_address = '0; m0_r_en = 1'b0;
        m1_address = '0; m1_wdata = '0; m1_r_en = 1'b0; m1_w_en = 1'b0;
        sram_rdata = '0; sram_ready = 1'b0;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_r_en", sram_r_en, 1'b0);
        check("rst_w_en", sram_w_en, 1'b0);
        check("rst_addr", sram_address, 18'h0);
        check("rst_wdata", sram_wdata, 32'h0);
        check("rst_m0_ready", m0_ready, 1'b1);
        check("rst_m1_ready", m1_ready, 1'b1);
        check("rst_terr", timeout_err, 1'b0);
        m0_r_en = 1'b1; #1;
        check("rst_m0_ready_req", m0_ready, 1'b0);
        m0_r_en = 1'b0;
        repeat (2) tick;
        rst = 1'b1;

        // m0 alone, sram_ready on third busy cycle
        tick;
        m0_address = 18'h00010; m0_r_en = 1'b1; #1;
        check("t1_idle_grant", grant, 2'b00);
        check("t1_idle_r_en", sram_r_en, 1'b0);
        check("t1_idle_ready", m0_ready, 1'b0);
        tick;
        check("t1_c1_r_en", sram_r_en, 1'b1);
        check("t1_c1_addr", sram_address, 18'h00010);
        check("t1_c1_grant", grant, 2'b01);
        check("t1_c1_ready", m0_ready, 1'b0);
        tick;
        check("t1_c2_ready", m0_ready, 1'b0);
        tick;
        sram_ready = 1'b1; sram_rdata = 64'h0123_4567_89AB_CDEF; #1;
        check("t1_c3_ready", m0_ready, 1'b1);
        check("t1_c3_rdata", m0_rdata, 64'h0123_4567_89AB_CDEF);
        tick;
        sram_ready = 1'b0; m0_r_en = 1'b0; #1;
        check("t1_end_grant", grant, 2'b00);
        check("t1_end_r_en", sram_r_en, 1'b0);
        check("t1_end_addr", sram_address, 18'h0);

        // contention right after reset: m0, m1, m0, m1
        rst = 1'b0; #1; rst = 1'b1;
        m0_address = 18'h00100; m1_address = 18'h00200;
        m0_r_en = 1'b1; m1_r_en = 1'b1; #1;
        check("t2_idle_grant", grant, 2'b00);
        tick;
        check("t2_a_grant", grant, 2'b01);
        check("t2_a_addr", sram_address, 18'h00100);
        sram_ready = 1'b1; #1;
        check("t2_a_m0_ready", m0_ready, 1'b1);
        check("t2_a_m1_ready", m1_ready, 1'b0);
        tick;
        sram_ready = 1'b0; m0_r_en = 1'b0; #1;
        check("t2_dead_grant", grant, 2'b00);
        check("t2_dead_r_en", sram_r_en, 1'b0);
        check("t2_dead_m1_ready", m1_ready, 1'b0);
        tick;
        check("t2_b_grant", grant, 2'b10);
        check("t2_b_addr", sram_address, 18'h00200);
        sram_ready = 1'b1; #1;
        check("t2_b_m1_ready", m1_ready, 1'b1);
        tick;
        sram_ready = 1'b0; m1_r_en = 1'b0; #1;
        check("t2_b_end_grant", grant, 2'b00);
        tick;
        for (int k = 0; k < 2; k++) begin
            m0_r_en = 1'b1; m1_r_en = 1'b1;
            tick;
            check("t2_rr_grant", grant, (k == 0) ? 2'b01 : 2'b10);
            sram_ready = 1'b1; #1;
            check("t2_rr_m0_ready", m0_ready, (k == 0) ? 1'b1 : 1'b0);
            check("t2_rr_m1_ready", m1_ready, (k == 0) ? 1'b0 : 1'b1);
            tick;
            sram_ready = 1'b0; m0_r_en = 1'b0; m1_r_en = 1'b0; #1;
            check("t2_rr_idle", grant, 2'b00);
            tick;
        end

        // m1 with both enables: write wins
        m1_address = 18'h3FFFF; m1_wdata = 32'hDEADBEEF;
        m1_w_en = 1'b1; m1_r_en = 1'b1;
        tick;
        check("t3_grant", grant, 2'b10);
        check("t3_w_en", sram_w_en, 1'b1);
        check("t3_r_en", sram_r_en, 1'b0);
        check("t3_wdata", sram_wdata, 32'hDEADBEEF);
        check("t3_addr", sram_address, 18'h3FFFF);
        check("t3_c1_ready", m1_ready, 1'b0);
        tick;
        check("t3_c2_ready", m1_ready, 1'b0);
        sram_ready = 1'b1; #1;
        check("t3_ready", m1_ready, 1'b1);
        tick;
        sram_ready = 1'b0; m1_w_en = 1'b0; m1_r_en = 1'b0; #1;
        check("t3_end_wdata", sram_wdata, 32'h0);
        check("t3_end_w_en", sram_w_en, 1'b0);

        // SRAM never answers: watchdog on 16th busy cycle
        m0_address = 18'h00123; m0_r_en = 1'b1;
        tick;
        for (int i = 1; i < 16; i++) begin
            check("t4_wait_ready", m0_ready, 1'b0);
            tick;
        end
        check("t4_fire_ready", m0_ready, 1'b1);
        check("t4_fire_terr", timeout_err, 1'b0);
        check("t4_fire_r_en", sram_r_en, 1'b1);
        tick;
        m0_r_en = 1'b0; #1;
        check("t4_terr_set", timeout_err, 1'b1);
        check("t4_idle_grant", grant, 2'b00);
        m1_address = 18'h00456; m1_r_en = 1'b1;
        tick;
        check("t4_next_grant", grant, 2'b10);
        sram_ready = 1'b1; #1;
        check("t4_next_ready", m1_ready, 1'b1);
        tick;
        sram_ready = 1'b0; m1_r_en = 1'b0; #1;
        check("t4_terr_sticky", timeout_err, 1'b1);

        // sram_ready on exactly the 16th busy cycle is a normal completion
        rst = 1'b0; #1; rst = 1'b1; #1;
        check("t5_terr_clr", timeout_err, 1'b0);
        m0_r_en = 1'b1;
        tick;
        for (int i = 1; i < 16; i++) tick;
        sram_ready = 1'b1; #1;
        check("t5_ready", m0_ready, 1'b1);
        tick;
        sram_ready = 1'b0; m0_r_en = 1'b0; #1;
        check("t5_terr", timeout_err, 1'b0);
        check("t5_grant", grant, 2'b00);

        // async reset in the middle of an m1 write
        m1_address = 18'h00ABC; m1_wdata = 32'hCAFEF00D; m1_w_en = 1'b1;
        tick;
        check("t6_w_en", sram_w_en, 1'b1);
        #1 rst = 1'b0; #1;
        check("t6_rst_w_en", sram_w_en, 1'b0);
        check("t6_rst_grant", grant, 2'b00);
        check("t6_rst_ready", m1_ready, 1'b0);
        sram_ready = 1'b1; #1;
        check("t6_rst_ready_ign", m1_ready, 1'b0);
        sram_ready = 1'b0;
        tick;
        rst = 1'b1; #1;
        check("t6_rel_grant", grant, 2'b00);
        check("t6_rel_ready", m1_ready, 1'b0);
        tick;
        check("t6_re_grant", grant, 2'b10);
        check("t6_re_wdata", sram_wdata, 32'hCAFEF00D);
        sram_ready = 1'b1; #1;
        check("t6_re_ready", m1_ready, 1'b1);
        tick;
        sram_ready = 1'b0; m1_w_en = 1'b0; #1;
        check("t6_end_grant", grant, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
